// File: rtl/seq_step_controller_if.sv
// seq_step_controller_if: control inputs and step/status outputs of the step sequencer
interface seq_step_controller_if #(parameter int NSTEP = 4, parameter int CW = 24);
  logic            start;
  logic            abort;
  logic            mode;
  logic [CW-1:0]   dur;
  logic [NSTEP-1:0] step_out;
  logic [3:0]      step_idx;
  logic            busy;
  logic            done;
  modport master (output start, abort, mode, dur, input step_out, step_idx, busy, done);
  modport slave  (input start, abort, mode, dur, output step_out, step_idx, busy, done);
endinterface

// File: rtl/seq_step_controller.sv
// seq_step_controller: one-hot step sequencer with a shared down-counter, loop mode and done pulse.
// Define SEQ_RETRIG_EN to let a start event during RUN restart the sequence.
module seq_step_controller #(
  parameter int NSTEP = 4,
  parameter int CW = 24
) (
  input logic clk_i,
  input logic r_n_i,
  seq_step_controller_if.slave bus
);
`ifdef SEQ_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  localparam logic [3:0] LAST = 4'(NSTEP - 1);
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q;
  logic s1_q, s2_q, s3_q;
  logic [CW-1:0] dur_q, cnt_q;
  logic [3:0] idx_q;
  logic [NSTEP-1:0] step_q;
  logic busy_q, done_q;
  logic start_ev;
  logic [CW-1:0] dur_d;
  assign start_ev = s2_q & ~s3_q;
  assign dur_d = (bus.dur == '0) ? ONE : bus.dur;
  assign bus.step_out = step_q;
  assign bus.step_idx = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  always_ff @(posedge clk_i) begin
    if (!r_n_i) begin
      state_q <= IDLE;
      {s1_q, s2_q, s3_q} <= 3'b000;
      dur_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      step_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      {s1_q, s2_q, s3_q} <= {bus.start, s1_q, s2_q};
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q <= IDLE;
        cnt_q <= '0;
        idx_q <= '0;
        step_q <= '0;
        busy_q <= 1'b0;
      end else if (start_ev && (state_q == IDLE || RETRIG)) begin
        state_q <= RUN;
        dur_q <= dur_d;
        cnt_q <= dur_d - ONE;
        idx_q <= '0;
        step_q <= {{(NSTEP-1){1'b0}}, 1'b1};
        busy_q <= 1'b1;
      end else if (state_q == RUN) begin
        // terminal count of a step: advance, wrap in loop mode, or finish the pass
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - ONE;
        end else if (idx_q != LAST) begin
          idx_q <= idx_q + 4'd1;
          cnt_q <= dur_q - ONE;
          step_q <= step_q << 1;
        end else if (bus.mode) begin
          idx_q <= '0;
          cnt_q <= dur_q - ONE;
          step_q <= {{(NSTEP-1){1'b0}}, 1'b1};
        end else begin
          state_q <= IDLE;
          idx_q <= '0;
          step_q <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_step_controller.sv
// tb_seq_step_controller: directed plus random stimulus against an elapsed-time reference model
module tb_seq_step_controller;
  localparam int NSTEP = 4;
  localparam int CW = 24;
`ifdef SEQ_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  logic clk = 1'b0;
  logic rn = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  logic [2:0] m_s = '0;
  bit m_run = 0;
  bit m_done = 0;
  int m_d = 1;
  int m_e = 0;
  seq_step_controller_if #(.NSTEP(NSTEP), .CW(CW)) bus ();
  seq_step_controller #(.NSTEP(NSTEP), .CW(CW)) dut (.clk_i(clk), .r_n_i(rn), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic int m_idx();
    return m_run ? m_e / m_d : 0;
  endfunction
  // Model: a pass is NSTEP*d elapsed cycles; the active step is elapsed/d.
  task automatic tick();
    bit ev;
    logic [NSTEP-1:0] one;
    logic [NSTEP-1:0] exp_step;
    logic [3:0] exp_idx;
    @(posedge clk);
    ev = m_s[1] & ~m_s[2];
    m_done = 0;
    if (!rn) begin
      m_s = '0;
      m_run = 0;
    end else begin
      m_s = {m_s[1:0], bus.start};
      if (bus.abort) m_run = 0;
      else if (ev && (!m_run || RETRIG)) begin
        m_run = 1;
        m_d = (bus.dur == '0) ? 1 : int'(bus.dur);
        m_e = 0;
      end else if (m_run) begin
        m_e++;
        if (m_e == NSTEP * m_d) begin
          if (bus.mode) m_e = 0;
          else begin
            m_run = 0;
            m_done = 1;
          end
        end
      end
    end
    #1;
    one = 1;
    exp_idx = 4'(m_idx());
    exp_step = m_run ? one << exp_idx : '0;
    compared++;
    assert (bus.step_out === exp_step) else begin
      mismatched++;
      $error("FAIL step_out got %b exp %b at %0t", bus.step_out, exp_step, $time);
    end
    compared++;
    assert (bus.step_idx === exp_idx) else begin
      mismatched++;
      $error("FAIL step_idx got %0d exp %0d at %0t", bus.step_idx, exp_idx, $time);
    end
    compared++;
    assert (bus.busy === m_run) else begin
      mismatched++;
      $error("FAIL busy got %b exp %b at %0t", bus.busy, m_run, $time);
    end
    compared++;
    assert (bus.done === m_done) else begin
      mismatched++;
      $error("FAIL done got %b exp %b at %0t", bus.done, m_done, $time);
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic wait_elapsed(input int e);
    int k;
    for (k = 0; k < 500 && !(m_run && m_e == e); k++) tick();
    compared++;
    assert (k < 500) else begin
      mismatched++;
      $error("FAIL wait_elapsed timeout got %0d exp %0d", m_e, e);
    end
  endtask
  task automatic check_count(input string tag, input int got, input int exp);
    compared++;
    assert (got == exp) else begin
      mismatched++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode = 1'b0;
    bus.dur = 24'd5;
    ticks(3);
    rn = 1'b1;
    ticks(2);
    busy_cnt = 0;
    done_cnt = 0;
    pulse_start();
    ticks(30);
    check_count("single_busy", busy_cnt, 20);
    check_count("single_done", done_cnt, 1);
    foreach (m_s[i]) begin end
    for (int d = 0; d < 2; d++) begin
      bus.dur = 24'(d);
      busy_cnt = 0;
      done_cnt = 0;
      pulse_start();
      ticks(10);
      check_count("short_busy", busy_cnt, 4);
      check_count("short_done", done_cnt, 1);
    end
    bus.dur = 24'd3;
    bus.mode = 1'b1;
    done_cnt = 0;
    pulse_start();
    ticks(40);
    check_count("loop_no_done", done_cnt, 0);
    wait_elapsed(7);
    bus.mode = 1'b0;
    ticks(20);
    check_count("loop_exit_done", done_cnt, 1);
    bus.dur = 24'd10;
    done_cnt = 0;
    pulse_start();
    wait_elapsed(25);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_count("abort_busy", int'(bus.busy), 0);
    ticks(5);
    check_count("abort_done", done_cnt, 0);
    pulse_start();
    wait_elapsed(12);
    rn = 1'b0;
    tick();
    rn = 1'b1;
    check_count("reset_step", int'(bus.step_out), 0);
    ticks(3);
    bus.dur = 24'd5;
    done_cnt = 0;
    pulse_start();
    wait_elapsed(16);
    bus.dur = 24'd7;
    pulse_start();
    ticks(50);
    check_count("retrig_done", done_cnt, 1);
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(7) == 0);
      bus.abort = ($urandom_range(31) == 0);
      bus.mode = $urandom_range(1) == 1;
      bus.dur = 24'($urandom_range(4));
      rn = ($urandom_range(63) != 0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
